// File: rtl/addepreamble_pkg.sv
// Shared Ethernet framing constants and FSM state encoding for the preamble inserter.
package addepreamble_pkg;

  localparam int         ETH_OCTET_W        = 8;
  localparam logic [7:0] ETH_PREAMBLE_OCTET = 8'h55;
  localparam logic [7:0] ETH_SFD            = 8'hd5;
  localparam int         ETH_MIN_IFG        = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_DATA = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

endpackage

// File: rtl/addepreamble_if.sv
// Octet-stream bus between the CRC appender, the preamble inserter and the nibble serializer.
interface addepreamble_if;
  import addepreamble_pkg::*;

  logic                   i_ce;
  logic                   i_v;
  logic [ETH_OCTET_W-1:0] i_d;
  logic                   o_v;
  logic [ETH_OCTET_W-1:0] o_d;
  logic                   o_busy;

  modport master (output i_ce, i_v, i_d, input o_v, o_d, o_busy);
  modport slave  (input i_ce, i_v, i_d, output o_v, o_d, o_busy);

endinterface

// File: rtl/addepreamble_octet_delay.sv
// Fixed-depth {valid,octet} shift register advancing on the octet clock enable.
module addepreamble_octet_delay
  import addepreamble_pkg::*;
#(
  parameter int STAGES = 8,
  parameter int DATA_W = ETH_OCTET_W
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_ce,
  input  logic              i_v,
  input  logic [DATA_W-1:0] i_d,
  output logic              o_v,
  output logic [DATA_W-1:0] o_d
);

  logic [STAGES-1:0] vld_p;
  logic [DATA_W-1:0] dat_p [STAGES];

  // Only the valid bits are cleared; octets behind an invalid flag are never observed.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      vld_p <= '0;
    end else if (i_ce) begin
      vld_p[0] <= i_v;
      for (int s = 1; s < STAGES; s++) begin
        vld_p[s] <= vld_p[s-1];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_ce) begin
      dat_p[0] <= i_d;
      for (int s = 1; s < STAGES; s++) begin
        dat_p[s] <= dat_p[s-1];
      end
    end
  end

  assign o_v = vld_p[STAGES-1];
  assign o_d = dat_p[STAGES-1];

endmodule

// File: rtl/addepreamble.sv
// Prepends 55x PRE_BYTES + d5 to each framed octet stream and enforces the inter-frame gap.
// Define ADDEPREAMBLE_IFG_EN to build the GAP state and IFG counter; otherwise frames may abut.
module addepreamble
  import addepreamble_pkg::*;
#(
  parameter int PRE_BYTES = 7,
  parameter int IFG_BYTES = ETH_MIN_IFG,
  parameter int LGIFG     = 4
) (
  input  logic           i_clk,
  input  logic           i_reset,
  addepreamble_if.slave  bus
);

  localparam int PRE_W = $clog2(PRE_BYTES + 1);

  if (PRE_BYTES < 1 || IFG_BYTES < 1 || IFG_BYTES >= (1 << LGIFG)) begin : g_param_check
    $error("addepreamble: PRE_BYTES/IFG_BYTES out of range for LGIFG");
  end

  state_t                 state;
  logic [PRE_W-1:0]       pre_cnt;
  logic                   in_frame;
  logic                   push_v;
  logic                   tail_v;
  logic [ETH_OCTET_W-1:0] tail_d;
`ifdef ADDEPREAMBLE_IFG_EN
  logic [LGIFG-1:0]       ifg_cnt;
`endif

  // Once a frame's first idle octet is seen, anything offered before IDLE is dropped.
  assign push_v = bus.i_v && (state == ST_IDLE || in_frame);

  addepreamble_octet_delay #(
    .STAGES (PRE_BYTES + 1),
    .DATA_W (ETH_OCTET_W)
  ) u_delay (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_ce    (bus.i_ce),
    .i_v     (push_v),
    .i_d     (bus.i_d),
    .o_v     (tail_v),
    .o_d     (tail_d)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state      <= ST_IDLE;
      pre_cnt    <= '0;
      in_frame   <= 1'b0;
      bus.o_v    <= 1'b0;
      bus.o_d    <= '0;
      bus.o_busy <= 1'b0;
`ifdef ADDEPREAMBLE_IFG_EN
      ifg_cnt    <= '0;
`endif
    end else if (bus.i_ce) begin
      if (in_frame && !bus.i_v) begin
        in_frame <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          bus.o_v    <= 1'b0;
          bus.o_d    <= '0;
          bus.o_busy <= 1'b0;
          if (bus.i_v) begin
            state      <= ST_PRE;
            pre_cnt    <= PRE_W'(1);
            in_frame   <= 1'b1;
            bus.o_v    <= 1'b1;
            bus.o_d    <= ETH_PREAMBLE_OCTET;
            bus.o_busy <= 1'b1;
          end
        end
        ST_PRE: begin
          if (pre_cnt == PRE_W'(PRE_BYTES)) begin
            bus.o_d <= ETH_SFD;
            state   <= ST_DATA;
          end else begin
            bus.o_d <= ETH_PREAMBLE_OCTET;
            pre_cnt <= pre_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (tail_v) begin
            bus.o_v <= 1'b1;
            bus.o_d <= tail_d;
          end else begin
            bus.o_v <= 1'b0;
            bus.o_d <= '0;
`ifdef ADDEPREAMBLE_IFG_EN
            state   <= ST_GAP;
            ifg_cnt <= LGIFG'(IFG_BYTES - 1);
`else
            state      <= ST_IDLE;
            bus.o_busy <= 1'b0;
`endif
          end
        end
        ST_GAP: begin
`ifdef ADDEPREAMBLE_IFG_EN
          // Leaving on the 1->0 step gives exactly IFG_BYTES idle octets before o_v can rise.
          if (ifg_cnt <= LGIFG'(1)) begin
            ifg_cnt    <= '0;
            state      <= ST_IDLE;
            bus.o_busy <= 1'b0;
          end else begin
            ifg_cnt <= ifg_cnt - 1'b1;
          end
`else
          state      <= ST_IDLE;
          bus.o_busy <= 1'b0;
`endif
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addepreamble.sv
// Scoreboard bench for addepreamble: randomized and directed frames against a frame-level model.
module tb_addepreamble;

  localparam int PRE = 7;
`ifdef ADDEPREAMBLE_IFG_EN
  localparam int MIN_GAP = 12;
`else
  localparam int MIN_GAP = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;

  addepreamble_if bus();

  addepreamble dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int         nvec = 0;
  int         nmis = 0;
  logic [7:0] exp_q[$];
  int         len_q[$];
  int         start_q[$];
  int         ce_edges = 0;
  int         last_gap = -1;
  logic [7:0] frame_buf [256];

  task automatic check(input string name, input longint act, input longint req);
    nvec++;
    if (act != req) begin
      nmis++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Frame-level reference: preamble, SFD, then the payload unchanged.
  task automatic push_model(input int n);
    for (int i = 0; i < PRE; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hd5);
    for (int i = 0; i < n; i++) exp_q.push_back(frame_buf[i]);
    len_q.push_back(PRE + 1 + n);
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) frame_buf[i] = 8'($urandom);
  endtask

  task automatic step(input logic v, input logic [7:0] d, input int cediv);
    bus.i_v = v;
    bus.i_d = d;
    for (int j = 1; j < cediv; j++) begin
      bus.i_ce = 1'b0;
      @(posedge clk); #1;
    end
    bus.i_ce = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input int cediv);
    int k;
    k = 0;
    while (bus.o_busy === 1'b1 && k < 400) begin
      step(1'b0, 8'h00, cediv);
      k++;
    end
    check("idle_wait", bus.o_busy, 0);
  endtask

  task automatic send_frame(input int n, input int cediv);
    wait_idle(cediv);
    push_model(n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, frame_buf[i], cediv);
      if (i == 0) start_q.push_back(ce_edges);
    end
    bus.i_v = 1'b0;
  endtask

  // Monitor: one sample per clock, new output expected only after an i_ce edge.
  logic       ce_s;
  logic       prev_v = 1'b0;
  logic [7:0] prev_d = 8'h00;
  int         run = 0;
  int         gap = 0;
  bit         have_prev = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      ce_s = bus.i_ce;
      if (ce_s && !rst) ce_edges++;
      @(negedge clk);
      if (rst) begin
        run = 0; gap = 0; have_prev = 1'b0; prev_v = 1'b0; prev_d = 8'h00;
      end else if (!ce_s) begin
        check("hold", {bus.o_v, bus.o_d}, {prev_v, prev_d});
      end else begin
        if (bus.o_v) begin
          if (run == 0) begin
            if (have_prev) begin
              last_gap = gap;
              nvec++;
              if (gap < MIN_GAP) begin
                nmis++;
                $display("FAIL ifg_min: gap %0d, required at least %0d", gap, MIN_GAP);
              end
            end
            if (start_q.size() == 0) begin
              nvec++; nmis++;
              $display("FAIL unexpected_start: o_v rose with no frame pending, o_d=%0h", bus.o_d);
            end else begin
              check("start_edge", ce_edges, start_q.pop_front());
            end
          end
          run++;
          if (exp_q.size() == 0) begin
            nvec++; nmis++;
            $display("FAIL unexpected_octet: o_d=%0h with empty scoreboard", bus.o_d);
          end else begin
            check("octet", bus.o_d, exp_q.pop_front());
          end
        end else begin
          if (run > 0) begin
            if (len_q.size() == 0) begin
              nvec++; nmis++;
              $display("FAIL run_len: run of %0d with no frame expected", run);
            end else begin
              check("run_len", run, len_q.pop_front());
            end
            have_prev = 1'b1;
            gap = 0;
          end
          gap++;
          run = 0;
          check("idle_o_d", bus.o_d, 0);
        end
        prev_v = bus.o_v;
        prev_d = bus.o_d;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    int c;
    int k;
    bus.i_ce = 1'b0;
    bus.i_v  = 1'b0;
    bus.i_d  = 8'h00;
    #1 rst = 1'b1;
    #2;
    check("rst_o_v", bus.o_v, 0);
    check("rst_o_d", bus.o_d, 0);
    check("rst_o_busy", bus.o_busy, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    frame_buf[0] = 8'h01; frame_buf[1] = 8'h02; frame_buf[2] = 8'h03;
    send_frame(3, 1);
    send_frame(3, 4);

    // Second frame offered right after the first ends must be dropped.
    fill(5);
    send_frame(5, 1);
    step(1'b0, 8'h00, 1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 8'($urandom), 1);
      check("busy_while_drop", bus.o_busy, 1);
    end
    k = 0;
    while (bus.o_busy === 1'b1 && k < 100) begin
      step(1'($urandom_range(0, 1)), 8'($urandom), 1);
      k++;
    end
    bus.i_v = 1'b0;
    fill(4);
    send_frame(4, 1);
    step(1'b0, 8'h00, 1);
    check("ifg_gap", last_gap, MIN_GAP);

    // Asynchronous reset in the middle of the data phase.
    wait_idle(1);
    fill(20);
    push_model(20);
    for (int i = 0; i < 12; i++) begin
      step(1'b1, frame_buf[i], 1);
      if (i == 0) start_q.push_back(ce_edges);
    end
    #2 rst = 1'b1;
    #1;
    check("arst_o_v", bus.o_v, 0);
    check("arst_o_d", bus.o_d, 0);
    check("arst_o_busy", bus.o_busy, 0);
    exp_q.delete();
    len_q.delete();
    start_q.delete();
    bus.i_v = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    fill(6);
    send_frame(6, 1);

    fill(64);
    send_frame(64, 1);

    for (int f = 0; f < 8; f++) begin
      n = $urandom_range(1, 70);
      c = $urandom_range(1, 4);
      fill(n);
      send_frame(n, c);
      repeat ($urandom_range(0, 4)) step(1'b0, 8'h00, c);
    end

    wait_idle(1);
    repeat (4) step(1'b0, 8'h00, 1);
    check("exp_q_empty", exp_q.size(), 0);
    check("len_q_empty", len_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
